spike_gen: RTL and testbench
============================

SPIKE_GEN -- requirements
Module: spike_gen

Interface
REQ-001 Parameter DATA_W, default 12: sample width in bits, signed two's complement.
REQ-002 Parameter CNT_W, default 8: width of the gap and spike-count fields.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: request to begin a burst; sampled only in IDLE.
REQ-006 Port baseline, input, DATA_W signed: sample level outside spikes.
REQ-007 Port peak, input, DATA_W signed: sample level during the high phase of a spike.
REQ-008 Port high_len, input, 4 unsigned: number of peak samples per spike.
REQ-009 Port gap_len, input, CNT_W unsigned: number of baseline samples before each spike and after the last one.
REQ-010 Port n_spikes, input, CNT_W unsigned: number of spikes in the burst.
REQ-011 Port q, output, DATA_W signed: sample stream, one sample per clock, for the threshold detector input.
REQ-012 Port q_valid, output, 1: high when q carries a burst sample.
REQ-013 Port busy, output, 1: high from the cycle after an accepted start until done.
REQ-014 Port done, output, 1: one-cycle pulse when the burst completes.

Function
REQ-015 All outputs shall be registered, with no combinational path from any input to any output.
REQ-016 Start acceptance: start=1 in IDLE shall latch baseline, peak, high_len, gap_len and n_spikes. Later input changes shall not affect the running burst.
REQ-017 Start while busy shall be ignored, with no queuing.
REQ-018 FSM states shall be IDLE, GAP, HIGH, TAIL and DONE.
REQ-019 IDLE->GAP on an accepted start, except n_spikes=0, which goes IDLE->DONE.
REQ-020 GAP: q=baseline for gap_len cycles, then ->HIGH. gap_len=0 shall skip GAP straight to HIGH.
REQ-021 HIGH: q=peak for high_len cycles, then decrement the spike counter.
REQ-021a After a HIGH phase: if the counter is nonzero ->GAP, else ->TAIL.
REQ-021b high_len=0: the spike shall emit no peak samples but still count.
REQ-022 TAIL: q=baseline for gap_len cycles, then ->DONE. gap_len=0 shall skip TAIL.
REQ-023 DONE: lasts one cycle; done=1, busy=0, q_valid=0; then ->IDLE.
REQ-024 Latency: start seen at edge t shall produce the first burst sample on q with q_valid=1 in the cycle after edge t.
REQ-025 In GAP, HIGH and TAIL: q_valid=1 and busy=1.
REQ-026 In IDLE and DONE: q_valid=0 and busy=0. q shall hold the latched baseline (0 before the first burst).
REQ-027 Total q_valid cycles per burst shall be (n_spikes+1)*gap_len + n_spikes*high_len.
REQ-028 Counters shall be unsigned and shall never wrap. gap_len=255 and n_spikes=255 shall be honoured exactly.
REQ-029 No arithmetic shall be applied to sample values: q equals the latched baseline or peak bit-exactly, including negative values.

Reset
REQ-030 rst=1 at any edge, including mid-burst, shall force IDLE on the next cycle.
REQ-030a Reset values: q=0, q_valid=0, busy=0, done=0, counters=0, latched config=0.
REQ-031 rst shall take priority over start in the same cycle.
REQ-032 Reset shall not produce a done pulse.

Verification
REQ-033 The bench shall cover the following directed scenarios.
REQ-033a baseline=100, peak=500, high_len=3, gap_len=2, n_spikes=1 -> q sequence 100,100,500,500,500,100,100 with q_valid=1, then done pulse; detector at threshold 300 asserts spike.
REQ-033b n_spikes=3, high_len=2, gap_len=4 -> 22 valid samples, exactly 3 peak runs of length 2, one done pulse.
REQ-033c n_spikes=0 -> no q_valid, busy stays 0, done pulses in the cycle after start.
REQ-033d gap_len=0, high_len=4, n_spikes=2 -> 8 consecutive peak samples, no baseline samples inside the burst.
REQ-033e baseline=-2048, peak=2047 -> q toggles between exact extremes with no sign error; start re-pulsed mid-burst is ignored.
REQ-033f rst asserted in the 2nd HIGH cycle -> next cycle q=0, q_valid=0, busy=0, no done pulse; a new start then runs a full burst correctly.

Source files
------------

// File: rtl/spike_gen_if.sv
// Control and sample-stream bundle for the spike burst generator.
// The master drives burst configuration; the slave returns the sample stream.
interface spike_gen_if #(
   parameter int DATA_W = 12,
   parameter int CNT_W  = 8
);
   logic                     start;
   logic signed [DATA_W-1:0] baseline;
   logic signed [DATA_W-1:0] peak;
   logic [3:0]               high_len;
   logic [CNT_W-1:0]         gap_len;
   logic [CNT_W-1:0]         n_spikes;
   logic signed [DATA_W-1:0] q;
   logic                     q_valid;
   logic                     busy;
   logic                     done;

   modport master (
      output start, baseline, peak, high_len, gap_len, n_spikes,
      input  q, q_valid, busy, done
   );

   modport slave (
      input  start, baseline, peak, high_len, gap_len, n_spikes,
      output q, q_valid, busy, done
   );
endinterface

// File: rtl/spike_gen.sv
// Spike burst generator: gap/peak/tail sample stream for threshold-detector stimulus.
// Outputs are registered from the next-state decision, so a sample appears the cycle after start.
module spike_gen #(
   parameter int DATA_W = 12,
   parameter int CNT_W  = 8
) (
   input  logic     clk,
   input  logic     rst,
   spike_gen_if.slave bus
);

   typedef enum logic [2:0] {IDLE, GAP, HIGH, TAIL, DONE} state_t;

   state_t                   state;
   state_t                   nxt;
   logic [CNT_W-1:0]         cnt;
   logic [CNT_W-1:0]         nxt_cnt;
   logic [CNT_W-1:0]         spk;
   logic [CNT_W-1:0]         nxt_spk;
   logic [CNT_W-1:0]         gap_r;
   logic [3:0]               high_r;
   logic signed [DATA_W-1:0] base_r;
   logic signed [DATA_W-1:0] peak_r;

   logic                     acc;
   logic [CNT_W-1:0]         gap_s;
   logic [CNT_W-1:0]         high_s;
   logic signed [DATA_W-1:0] base_s;
   logic signed [DATA_W-1:0] peak_s;

   assign acc    = (state == IDLE) && bus.start;
   assign gap_s  = acc ? bus.gap_len : gap_r;
   assign high_s = CNT_W'(acc ? bus.high_len : high_r);
   assign base_s = acc ? bus.baseline : base_r;
   assign peak_s = acc ? bus.peak : peak_r;

   // Zero-length phases are skipped here so no state ever emits an empty cycle.
   always_comb begin
      nxt     = state;
      nxt_cnt = cnt;
      nxt_spk = spk;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               nxt_spk = bus.n_spikes;
               if (bus.n_spikes == '0) begin
                  nxt = DONE;
               end else if (gap_s != '0) begin
                  nxt     = GAP;
                  nxt_cnt = gap_s - CNT_W'(1);
               end else if (high_s != '0) begin
                  nxt     = HIGH;
                  nxt_cnt = high_s - CNT_W'(1);
               end else begin
                  nxt = DONE;
               end
            end
         end
         GAP: begin
            if (cnt != '0) begin
               nxt_cnt = cnt - CNT_W'(1);
            end else if (high_s != '0) begin
               nxt     = HIGH;
               nxt_cnt = high_s - CNT_W'(1);
            end else begin
               nxt_spk = spk - CNT_W'(1);
               nxt     = (spk != CNT_W'(1)) ? GAP : TAIL;
               nxt_cnt = gap_s - CNT_W'(1);
            end
         end
         HIGH: begin
            if (cnt != '0) begin
               nxt_cnt = cnt - CNT_W'(1);
            end else begin
               nxt_spk = spk - CNT_W'(1);
               if (spk != CNT_W'(1)) begin
                  if (gap_s != '0) begin
                     nxt     = GAP;
                     nxt_cnt = gap_s - CNT_W'(1);
                  end else begin
                     nxt     = HIGH;
                     nxt_cnt = high_s - CNT_W'(1);
                  end
               end else if (gap_s != '0) begin
                  nxt     = TAIL;
                  nxt_cnt = gap_s - CNT_W'(1);
               end else begin
                  nxt = DONE;
               end
            end
         end
         TAIL: begin
            if (cnt != '0) begin
               nxt_cnt = cnt - CNT_W'(1);
            end else begin
               nxt = DONE;
            end
         end
         DONE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         spk         <= '0;
         gap_r       <= '0;
         high_r      <= '0;
         base_r      <= '0;
         peak_r      <= '0;
         bus.q       <= '0;
         bus.q_valid <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         state <= nxt;
         cnt   <= nxt_cnt;
         spk   <= nxt_spk;
         if (acc) begin
            gap_r  <= bus.gap_len;
            high_r <= bus.high_len;
            base_r <= bus.baseline;
            peak_r <= bus.peak;
         end
         bus.q       <= (nxt == HIGH) ? peak_s : base_s;
         bus.q_valid <= (nxt == GAP) || (nxt == HIGH) || (nxt == TAIL);
         bus.busy    <= (nxt == GAP) || (nxt == HIGH) || (nxt == TAIL);
         bus.done    <= (nxt == DONE);
      end
   end

endmodule

// File: tb/tb_spike_gen.sv
// Directed bench for spike_gen: burst shapes, boundaries, reset behaviour.
// Inputs change and outputs are sampled on the falling edge.
module tb_spike_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_asrt = 0;
   int   n_fail = 0;

   logic signed [11:0] qs[$];
   logic signed [11:0] ex[$];

   spike_gen_if #(.DATA_W(12), .CNT_W(8)) bus ();

   spike_gen #(.DATA_W(12), .CNT_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic launch(input int bl, input int pk, input int hl,
                         input int gl, input int ns);
      @(negedge clk);
      bus.baseline = 12'(bl);
      bus.peak     = 12'(pk);
      bus.high_len = 4'(hl);
      bus.gap_len  = 8'(gl);
      bus.n_spikes = 8'(ns);
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.baseline = 12'sd7;
      bus.peak     = -12'sd7;
      bus.high_len = 4'd9;
      bus.gap_len  = 8'd9;
      bus.n_spikes = 8'd9;
   endtask

   // Collects valid samples until done; poke re-pulses start mid-burst.
   task automatic capture(input int poke, output bit tmo, output int dn,
                          output int berr);
      bit got;
      qs.delete();
      got  = 1'b0;
      dn   = 0;
      berr = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
         if (bus.busy !== bus.q_valid) berr++;
         if (bus.q_valid === 1'b1) qs.push_back(bus.q);
         if (bus.done === 1'b1) begin
            dn++;
            got = 1'b1;
         end else begin
            @(negedge clk);
            if (i == poke) begin
               bus.start    = 1'b1;
               bus.baseline = 12'sd0;
               bus.peak     = 12'sd0;
               bus.n_spikes = 8'd50;
            end
            if (i == poke + 1) bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      tmo = !got;
   endtask

   task automatic cmp_seq(input string nm);
      int bad;
      n_asrt++;
      if (qs.size() != ex.size()) begin
         n_fail++;
         $display("FAIL %s_len: got %0d samples, want %0d", nm, qs.size(), ex.size());
      end
      bad = -1;
      for (int i = 0; i < qs.size() && i < ex.size(); i++)
         if (qs[i] !== ex[i] && bad < 0) bad = i;
      n_asrt++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s_seq: idx %0d got %0d want %0d", nm, bad, qs[bad], ex[bad]);
      end
   endtask

   task automatic test_reset;
      bus.start = 1'b1;
      bus.baseline = 12'sd100;
      bus.peak = 12'sd500;
      bus.high_len = 4'd1;
      bus.gap_len = 8'd1;
      bus.n_spikes = 8'd1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_asrt += 4;
      if (bus.q !== 12'sd0) begin n_fail++; $display("FAIL rst_q: got %0d want 0", bus.q); end
      if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.q_valid); end
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
      bus.start = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_asrt += 2;
      if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", bus.q_valid); end
      if (bus.q !== 12'sd0) begin n_fail++; $display("FAIL idle_q: got %0d want 0", bus.q); end
   endtask

   task automatic test_single;
      bit tmo; int dn, berr; bit det;
      launch(100, 500, 3, 2, 1);
      n_asrt++;
      if (bus.q_valid !== 1'b1 || bus.q !== 12'sd100) begin
         n_fail++; $display("FAIL latency: got valid=%b q=%0d want valid=1 q=100", bus.q_valid, bus.q);
      end
      capture(-5, tmo, dn, berr);
      ex = '{100, 100, 500, 500, 500, 100, 100};
      n_asrt += 2;
      if (tmo) begin n_fail++; $display("FAIL single_tmo: got timeout want done"); end
      if (berr != 0) begin n_fail++; $display("FAIL single_busy: got %0d busy/valid diffs want 0", berr); end
      cmp_seq("single");
      det = 1'b0;
      foreach (qs[i]) if (qs[i] > 12'sd300) det = 1'b1;
      n_asrt++;
      if (!det) begin n_fail++; $display("FAIL detect300: got 0 want 1"); end
      @(negedge clk);
      n_asrt += 2;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b want 0", bus.done); end
      if (bus.q !== 12'sd100 || bus.q_valid !== 1'b0) begin
         n_fail++; $display("FAIL idle_hold: got q=%0d v=%b want q=100 v=0", bus.q, bus.q_valid);
      end
   endtask

   task automatic test_multi;
      bit tmo; int dn, berr; int runs, rl, badrl;
      launch(100, 500, 2, 4, 3);
      capture(-5, tmo, dn, berr);
      ex.delete();
      for (int s = 0; s < 3; s++) begin
         repeat (4) ex.push_back(12'sd100);
         repeat (2) ex.push_back(12'sd500);
      end
      repeat (4) ex.push_back(12'sd100);
      n_asrt += 2;
      if (tmo) begin n_fail++; $display("FAIL multi_tmo: got timeout want done"); end
      if (berr != 0) begin n_fail++; $display("FAIL multi_busy: got %0d diffs want 0", berr); end
      cmp_seq("multi");
      runs = 0; rl = 0; badrl = 0;
      foreach (qs[i]) begin
         if (qs[i] == 12'sd500) rl++;
         else begin
            if (rl != 0) begin runs++; if (rl != 2) badrl++; end
            rl = 0;
         end
      end
      n_asrt += 2;
      if (runs != 3) begin n_fail++; $display("FAIL multi_runs: got %0d want 3", runs); end
      if (badrl != 0) begin n_fail++; $display("FAIL multi_runlen: got %0d bad runs want 0", badrl); end
      @(negedge clk);
      n_asrt++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL multi_done1: got %b want 0", bus.done); end
   endtask

   task automatic test_zero;
      launch(100, 500, 3, 2, 0);
      n_asrt += 3;
      if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", bus.done); end
      if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid: got %b want 0", bus.q_valid); end
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", bus.busy); end
      @(negedge clk);
      n_asrt++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL zero_after: got done=%b busy=%b want 0 0", bus.done, bus.busy);
      end
   endtask

   task automatic test_gap0;
      bit tmo; int dn, berr;
      launch(100, 500, 4, 0, 2);
      capture(-5, tmo, dn, berr);
      ex.delete();
      repeat (8) ex.push_back(12'sd500);
      n_asrt++;
      if (tmo || berr != 0) begin n_fail++; $display("FAIL gap0_flow: got tmo=%b berr=%0d want 0 0", tmo, berr); end
      cmp_seq("gap0");
   endtask

   task automatic test_extremes;
      bit tmo; int dn, berr;
      launch(-2048, 2047, 1, 1, 3);
      capture(2, tmo, dn, berr);
      ex = '{-2048, 2047, -2048, 2047, -2048, 2047, -2048};
      n_asrt++;
      if (tmo || berr != 0) begin n_fail++; $display("FAIL ext_flow: got tmo=%b berr=%0d want 0 0", tmo, berr); end
      cmp_seq("extreme");
      @(negedge clk);
      n_asrt++;
      if (bus.busy !== 1'b0 || bus.q !== -12'sd2048) begin
         n_fail++; $display("FAIL ext_noqueue: got busy=%b q=%0d want 0 -2048", bus.busy, bus.q);
      end
   endtask

   task automatic test_reset_mid;
      bit tmo; int dn, berr; int dseen;
      launch(100, 500, 3, 2, 2);
      repeat (3) @(negedge clk);
      n_asrt++;
      if (bus.q !== 12'sd500) begin n_fail++; $display("FAIL mid_high2: got %0d want 500", bus.q); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_asrt += 4;
      if (bus.q !== 12'sd0) begin n_fail++; $display("FAIL mid_q: got %0d want 0", bus.q); end
      if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", bus.q_valid); end
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", bus.done); end
      dseen = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.q_valid === 1'b1) dseen++;
      end
      n_asrt++;
      if (dseen != 0) begin n_fail++; $display("FAIL mid_quiet: got %0d active cycles want 0", dseen); end
      launch(100, 500, 3, 2, 1);
      capture(-5, tmo, dn, berr);
      ex = '{100, 100, 500, 500, 500, 100, 100};
      n_asrt++;
      if (tmo || berr != 0) begin n_fail++; $display("FAIL rerun_flow: got tmo=%b berr=%0d want 0 0", tmo, berr); end
      cmp_seq("rerun");
   endtask

   task automatic test_long;
      bit tmo; int dn, berr; int np;
      launch(-5, 9, 1, 255, 2);
      capture(-5, tmo, dn, berr);
      np = 0;
      foreach (qs[i]) if (qs[i] == 12'sd9) np++;
      n_asrt += 3;
      if (tmo || berr != 0) begin n_fail++; $display("FAIL gap255_flow: got tmo=%b berr=%0d want 0 0", tmo, berr); end
      if (qs.size() != 767) begin n_fail++; $display("FAIL gap255_len: got %0d want 767", qs.size()); end
      if (np != 2) begin n_fail++; $display("FAIL gap255_peaks: got %0d want 2", np); end
      launch(3, 9, 0, 1, 255);
      capture(-5, tmo, dn, berr);
      np = 0;
      foreach (qs[i]) if (qs[i] != 12'sd3) np++;
      n_asrt += 3;
      if (tmo || berr != 0) begin n_fail++; $display("FAIL n255_flow: got tmo=%b berr=%0d want 0 0", tmo, berr); end
      if (qs.size() != 256) begin n_fail++; $display("FAIL n255_len: got %0d want 256", qs.size()); end
      if (np != 0) begin n_fail++; $display("FAIL n255_peaks: got %0d want 0", np); end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.baseline = '0;
      bus.peak = '0;
      bus.high_len = '0;
      bus.gap_len = '0;
      bus.n_spikes = '0;
      test_reset();
      test_single();
      test_multi();
      test_zero();
      test_gap0();
      test_extremes();
      test_reset_mid();
      test_long();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
